// File: rtl/output_mem_bank_router.sv
// output_mem_bank_router
//    Routes psum-controller read/write requests to NUM_MEM output-memory BRAM
//    banks. It also steers the returned read data back to the psum controller
//    in request order.
//    - A global address splits into a bank select, a local address and an
//      out-of-range check.
//    - A tag pipeline matched to the bank read latency remembers which bank,
//      if any, each outstanding read went to.
//    - Same-cycle read-after-write to the same address returns the write data.
//    - Out-of-range accesses and bank-return protocol violations are latched
//      into err_sticky.
// Ports
//    clk, rst_n        clock, synchronous active-low reset
//    psumctrl_w*       global write request (address, enable, data)
//    psumctrl_r*       global read request (address, enable)
//    psumctrl_o*       registered read return (data, valid, out-of-range flag)
//    err_sticky        [0] out-of-range access seen, [1] bank protocol error seen
//    bramctrl_*_rd     per-bank read request out, per-bank read data/valid in
//    bramctrl_*_wr     per-bank write request out, shared write data
module output_mem_bank_router #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int MEM_ADDR_WIDTH = 15,
   parameter int NUM_MEM_WIDTH  = 2,
   parameter int RD_LATENCY     = 1,
   localparam int NUM_MEM       = 2 ** NUM_MEM_WIDTH
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [ADDR_WIDTH-1:0]               psumctrl_wadd,
   input  logic                                psumctrl_wren,
   input  logic [DATA_WIDTH-1:0]               psumctrl_wdat,
   input  logic [ADDR_WIDTH-1:0]               psumctrl_radd,
   input  logic                                psumctrl_rden,
   output logic [DATA_WIDTH-1:0]               psumctrl_odat,
   output logic                                psumctrl_ovld,
   output logic                                psumctrl_oerr,
   output logic [1:0]                          err_sticky,
   output logic [NUM_MEM*MEM_ADDR_WIDTH-1:0]   bramctrl_addr_rd,
   output logic [NUM_MEM-1:0]                  bramctrl_rden_rd,
   input  logic [NUM_MEM*DATA_WIDTH-1:0]       bramctrl_odat_rd,
   input  logic [NUM_MEM-1:0]                  bramctrl_oval_rd,
   output logic [NUM_MEM*MEM_ADDR_WIDTH-1:0]   bramctrl_addr_wr,
   output logic [NUM_MEM-1:0]                  bramctrl_wren_wr,
   output logic [DATA_WIDTH-1:0]               bramctrl_wdat_wr
);

   localparam int MAW = MEM_ADDR_WIDTH;
   localparam int NMW = NUM_MEM_WIDTH;

   typedef struct packed {
      logic                  vld;
      logic [NMW-1:0]        sel;
      logic                  oor;
      logic                  byp;
      logic [DATA_WIDTH-1:0] bdat;
   } tag_t;

   logic [NMW-1:0]        rdSel, wrSel;
   logic [MAW-1:0]        rdLocal, wrLocal;
   logic                  rdInRange, wrInRange;
   logic                  rawHit;
   tag_t                  tagD;
   tag_t                  tagQ [RD_LATENCY];
   tag_t                  tagLast;
   logic [NUM_MEM-1:0]    matchMask;
   logic                  protoErr;
   logic                  oorAccess;
   logic [DATA_WIDTH-1:0] bankRdData;
   logic [DATA_WIDTH-1:0] odatD, odatQ;
   logic                  ovldQ, oerrQ;
   logic [1:0]            errStickyD, errStickyQ;

   // Split global addresses; anything above the bank-select field must be zero
   assign rdSel     = psumctrl_radd[MAW+NMW-1:MAW];
   assign rdLocal   = psumctrl_radd[MAW-1:0];
   assign rdInRange = (psumctrl_radd[ADDR_WIDTH-1:MAW+NMW] == '0);
   assign wrSel     = psumctrl_wadd[MAW+NMW-1:MAW];
   assign wrLocal   = psumctrl_wadd[MAW-1:0];
   assign wrInRange = (psumctrl_wadd[ADDR_WIDTH-1:MAW+NMW] == '0);

   assign rawHit = psumctrl_rden & psumctrl_wren & rdInRange & wrInRange
                 & (psumctrl_radd == psumctrl_wadd);

   assign oorAccess = (psumctrl_rden & ~rdInRange) | (psumctrl_wren & ~wrInRange);

   assign bramctrl_wdat_wr = psumctrl_wdat;

   // Bank requests are combinational; unselected banks see all-zero address and enable
   always_comb begin
      bramctrl_addr_rd = '0;
      bramctrl_rden_rd = '0;
      bramctrl_addr_wr = '0;
      bramctrl_wren_wr = '0;
      if (psumctrl_rden && rdInRange) begin
         bramctrl_rden_rd[rdSel]             = 1'b1;
         bramctrl_addr_rd[rdSel*MAW +: MAW]  = rdLocal;
      end
      if (psumctrl_wren && wrInRange) begin
         bramctrl_wren_wr[wrSel]             = 1'b1;
         bramctrl_addr_wr[wrSel*MAW +: MAW]  = wrLocal;
      end
   end

   // Tag entering the pipeline this cycle; write data is captured for the bypass case
   always_comb begin
      tagD = '0;
      if (psumctrl_rden) begin
         tagD.vld  = 1'b1;
         tagD.sel  = rdSel;
         tagD.oor  = ~rdInRange;
         tagD.byp  = rawHit;
         tagD.bdat = psumctrl_wdat;
      end
   end

   assign tagLast    = tagQ[RD_LATENCY-1];
   assign bankRdData = bramctrl_odat_rd[tagLast.sel*DATA_WIDTH +: DATA_WIDTH];

   // Only the bank named by the oldest in-range tag may raise oval this cycle
   always_comb begin
      matchMask = '0;
      for (int i = 0; i < NUM_MEM; i++) begin
         matchMask[i] = tagLast.vld & ~tagLast.oor & (tagLast.sel == NMW'(i));
      end
   end

   assign protoErr = (tagLast.vld & ~tagLast.oor & ~bramctrl_oval_rd[tagLast.sel])
                   | (|(bramctrl_oval_rd & ~matchMask));

   // Returned word follows the tag, never the bank valid
   always_comb begin
      odatD = bankRdData;
      if (tagLast.oor) begin
         odatD = '0;
      end else if (tagLast.byp) begin
         odatD = tagLast.bdat;
      end
   end

   assign errStickyD = errStickyQ | {protoErr, oorAccess};

   // Tag shift register plus the single return stage; reset drops in-flight reads
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LATENCY; i++) begin
            tagQ[i] <= '0;
         end
         odatQ      <= '0;
         ovldQ      <= 1'b0;
         oerrQ      <= 1'b0;
         errStickyQ <= '0;
      end else begin
         tagQ[0] <= tagD;
         for (int i = 1; i < RD_LATENCY; i++) begin
            tagQ[i] <= tagQ[i-1];
         end
         odatQ      <= odatD;
         ovldQ      <= tagLast.vld;
         oerrQ      <= tagLast.vld & tagLast.oor;
         errStickyQ <= errStickyD;
      end
   end

   assign psumctrl_odat = odatQ;
   assign psumctrl_ovld = ovldQ;
   assign psumctrl_oerr = oerrQ;
   assign err_sticky    = errStickyQ;

endmodule
